// File: rtl/inst_enc_pkg.sv
// Shared opcodes, FSM state type and decoded-field struct for the RV32I
// instruction encoder/loader.
package inst_enc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } inst_fields_t;

  // True when imm[31:lsb] are all copies of the sign bit, i.e. the value
  // fits in an (lsb+1)-bit signed field.
  function automatic logic upper_uniform(input logic [31:0] v, input int lsb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= lsb && v[i] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I format packer: muxes decoded fields into an instruction
// word and flags out-of-range or unknown tuples. U/J formats need INST_ENC_UJ_EN.
module inst_pack
  import inst_enc_pkg::*;
(
  input  inst_fields_t fields,
  output logic [31:0]  word,
  output logic         legal
);

  logic [31:0] imm;
  logic        fit_is;
  logic        fit_b;
`ifdef INST_ENC_UJ_EN
  logic        fit_u;
  logic        fit_j;
`endif

  assign imm    = fields.imm;
  assign fit_is = upper_uniform(imm, 11);
  assign fit_b  = upper_uniform(imm, 12) && !imm[0];
`ifdef INST_ENC_UJ_EN
  assign fit_u  = (imm[11:0] == 12'd0);
  assign fit_j  = upper_uniform(imm, 20) && !imm[0];
`endif

  always_comb begin
    word  = 32'd0;
    legal = 1'b0;
    case (fields.opcode)
      OP_LOAD, OP_IMM: begin
        word  = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
        legal = fit_is;
      end
      OP_STORE: begin
        word  = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
        legal = fit_is;
      end
      OP_BRANCH: begin
        word  = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                 imm[4:1], imm[11], fields.opcode};
        legal = fit_b;
      end
      OP_R: begin
        word  = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
        legal = 1'b1;
      end
`ifdef INST_ENC_UJ_EN
      OP_LUI, OP_AUIPC: begin
        word  = {imm[31:12], fields.rd, fields.opcode};
        legal = fit_u;
      end
      OP_JAL: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
        legal = fit_j;
      end
`endif
      default: begin
        word  = 32'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Encodes decoded RV32I field tuples and streams them to instruction memory at
// sequential addresses. Optional U/J formats: define INST_ENC_UJ_EN.
module inst_encoder_loader
  import inst_enc_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          opcode,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic signed [31:0]  imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [AW-1:0]       out_addr,
  output logic [31:0]         out_data,
  output logic                busy,
  output logic                done,
  output logic [7:0]          err_cnt
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] addr;
  inst_fields_t  fields_p0;
  logic [31:0]   word_p0;
  logic          legal_p0;
  logic          accept_p0;
  logic          drain_p0;
  logic          vld_p1;
  logic [31:0]   data_p1;
  logic [AW-1:0] addr_p1;

  assign fields_p0 = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                       funct3: funct3, funct7: funct7, imm: imm};

  inst_pack u_pack (
    .fields (fields_p0),
    .word   (word_p0),
    .legal  (legal_p0)
  );

  // Stall while the final word of the session is still waiting to drain.
  assign in_ready  = (state == ST_LOAD) && (!vld_p1 || out_ready) &&
                     !(vld_p1 && addr_p1 == LAST);
  assign accept_p0 = in_valid && in_ready;
  assign drain_p0  = vld_p1 && out_ready;

  // ---- p0 -> p1: session FSM, address counter, output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr    <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= 32'd0;
      addr_p1 <= '0;
      err_cnt <= 8'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (drain_p0) vld_p1 <= 1'b0;
      case (state)
        ST_IDLE, ST_FULL: begin
          if (start) begin
            state   <= ST_LOAD;
            addr    <= '0;
            err_cnt <= 8'd0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept_p0) begin
            if (legal_p0) begin
              vld_p1  <= 1'b1;
              data_p1 <= word_p0;
              addr_p1 <= addr;
              addr    <= addr + AW'(1);
            end else if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
          if (drain_p0 && addr_p1 == LAST) begin
            state <= ST_FULL;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_addr  = addr_p1;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader (DEPTH=4): vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_inst_encoder_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [6:0]        f_op = 7'd0;
  logic [4:0]        f_rd = 5'd0, f_rs1 = 5'd0, f_rs2 = 5'd0;
  logic [2:0]        f_f3 = 3'd0;
  logic [6:0]        f_f7 = 7'd0;
  logic signed [31:0] f_imm = 32'sd0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [AW-1:0]     out_addr;
  logic [31:0]       out_data;
  logic              busy, done;
  logic [7:0]        err_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_load, m_full, m_vld;
  logic [31:0] m_data;
  int          m_oaddr, m_addr, m_err;

  always #5 clk = ~clk;

  inst_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(f_op), .rd(f_rd), .rs1(f_rs1), .rs2(f_rs2), .funct3(f_f3), .funct7(f_f7),
    .imm(f_imm), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding from the ISA field layouts, using integer ranges and shifts.
  task automatic ref_encode(output logic [31:0] w, output bit lg);
    int          v;
    logic [31:0] u;
    logic [31:0] regs;
    v = int'(f_imm);
    u = f_imm;
    regs = (32'(f_rs1) << 15) | (32'(f_f3) << 12);
    w = 32'd0;
    lg = 1'b0;
    case (f_op)
      7'h03, 7'h13: begin
        lg = (v >= -2048) && (v <= 2047);
        w  = ((u & 32'hFFF) << 20) | regs | (32'(f_rd) << 7) | 32'(f_op);
      end
      7'h23: begin
        lg = (v >= -2048) && (v <= 2047);
        w  = (((u >> 5) & 32'h7F) << 25) | (32'(f_rs2) << 20) | regs |
             ((u & 32'h1F) << 7) | 32'(f_op);
      end
      7'h63: begin
        lg = (v >= -4096) && (v <= 4094) && ((v & 1) == 0);
        w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(f_rs2) << 20) |
             regs | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'(f_op);
      end
      7'h33: begin
        lg = 1'b1;
        w  = (32'(f_f7) << 25) | (32'(f_rs2) << 20) | regs | (32'(f_rd) << 7) | 32'(f_op);
      end
`ifdef INST_ENC_UJ_EN
      7'h37, 7'h17: begin
        lg = ((u & 32'hFFF) == 0);
        w  = (u & 32'hFFFFF000) | (32'(f_rd) << 7) | 32'(f_op);
      end
      7'h6F: begin
        lg = (v >= -(1 << 20)) && (v < (1 << 20)) && ((v & 1) == 0);
        w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20) |
             (((u >> 12) & 32'hFF) << 12) | (32'(f_rd) << 7) | 32'(f_op);
      end
`endif
      default: lg = 1'b0;
    endcase
  endtask

  task automatic model_reset();
    m_load = 0; m_full = 0; m_vld = 0; m_data = 0; m_oaddr = 0; m_addr = 0; m_err = 0;
  endtask

  // One clock: check in_ready, predict the edge, then compare every output.
  task automatic step();
    logic [31:0] w;
    bit lg, exp_rdy, acc, hs, was_load;
    #1;
    exp_rdy = m_load && (!m_vld || out_ready) && !(m_vld && m_oaddr == DEPTH - 1);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = in_valid && exp_rdy;
    hs = m_vld && out_ready;
    was_load = m_load;
    ref_encode(w, lg);
    @(posedge clk);
    if (hs) begin
      m_vld = 0;
      if (m_oaddr == DEPTH - 1) begin m_load = 0; m_full = 1; end
    end
    if (acc) begin
      if (lg) begin
        m_vld = 1; m_data = w; m_oaddr = m_addr; m_addr = (m_addr + 1) % DEPTH;
      end else if (m_err < 255) m_err++;
    end
    if (start && !was_load) begin m_load = 1; m_full = 0; m_addr = 0; m_err = 0; end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
    if (m_vld) begin
      chk("out_data", out_data, m_data);
      chk("out_addr", {30'd0, out_addr}, 32'(m_oaddr));
    end
    chk("err_cnt", {24'd0, err_cnt}, 32'(m_err));
    chk("busy", {31'd0, busy}, {31'd0, m_load});
    chk("done", {31'd0, done}, {31'd0, m_full});
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_addr", {30'd0, out_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_reset_values();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] rd_v, rs1_v, rs2_v,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] iv);
    f_op = op; f_rd = rd_v; f_rs1 = rs1_v; f_rs2 = rs2_v; f_f3 = f3; f_f7 = f7; f_imm = iv;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    bit          legal;
    logic [31:0] word;
  } vec_t;

  vec_t tbl[$];
  logic [6:0] op_pool [10] = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h13};

  initial begin
    tbl.push_back('{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          1, 32'h00500093}); // addi x1,x0,5
    tbl.push_back('{7'h03, 5'd2, 5'd1, 5'd0, 3'd2, 7'd0, 32'd8,          1, 32'h0080A103}); // lw
    tbl.push_back('{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4,          1, 32'h0020A223}); // sw
    tbl.push_back('{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8,   1, 32'hFE208CE3}); // beq -8
    tbl.push_back('{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd6,          1, 32'h00208363});
    tbl.push_back('{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094,       1, 32'h7E208FE3});
    tbl.push_back('{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFF000,   1, 32'h80208063});
    tbl.push_back('{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF,  1, 32'h002081B3}); // add
    tbl.push_back('{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,         1, 32'h402081B3}); // sub
    tbl.push_back('{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF,   1, 32'hFFF00093});
    tbl.push_back('{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800,   1, 32'h80000093});
    tbl.push_back('{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,       1, 32'h7FF00093});
    tbl.push_back('{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFF,   1, 32'hFE20AFA3});
    tbl.push_back('{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       0, 32'd0});
    tbl.push_back('{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,          0, 32'd0});
    tbl.push_back('{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096,       0, 32'd0});
    tbl.push_back('{7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0,          0, 32'd0});

    model_reset();
    #12;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: each tuple in a fresh session.
    for (int i = 0; i < tbl.size(); i++) begin
      do_reset();
      pulse_start();
      set_fields(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].f7, tbl[i].imm);
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].legal});
      if (tbl[i].legal) chk($sformatf("tbl%0d_word", i), out_data, tbl[i].word);
      chk($sformatf("tbl%0d_err", i), {24'd0, err_cnt}, tbl[i].legal ? 32'd0 : 32'd1);
      step();
    end

    // lw then sw back to back: one word per cycle.
    do_reset();
    pulse_start();
    out_ready = 1'b1; in_valid = 1'b1;
    set_fields(7'h03, 5'd2, 5'd1, 5'd0, 3'd2, 7'd0, 32'd8);
    step();
    set_fields(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4);
    chk("b2b_w0", out_data, 32'h0080A103);
    step();
    in_valid = 1'b0;
    chk("b2b_w1", out_data, 32'h0020A223);
    chk("b2b_a1", {30'd0, out_addr}, 32'd1);
    step();

    // Three illegal tuples: nothing written, addr unchanged.
    do_reset();
    pulse_start();
    in_valid = 1'b1;
    set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048); step();
    set_fields(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);    step();
    set_fields(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);    step();
    chk("ill_err3", {24'd0, err_cnt}, 32'd3);
    chk("ill_novld", {31'd0, out_valid}, 32'd0);
    set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);    step();
    in_valid = 1'b0;
    chk("ill_addr0", {30'd0, out_addr}, 32'd0);
    step();

    // Backpressure: out_ready low for 3 cycles with in_valid high.
    do_reset();
    pulse_start();
    out_ready = 1'b0; in_valid = 1'b1;
    set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    set_fields(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_stable", out_data, 32'h00500093);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next", out_data, 32'h00700113);
    in_valid = 1'b0;
    step();

    // Fill DEPTH words, restart, then reset mid-session with a word pending.
    do_reset();
    pulse_start();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      set_fields(7'h33, 5'(k), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      step();
    end
    in_valid = 1'b0;
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_busy", {31'd0, busy}, 32'd0);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    pulse_start();
    in_valid = 1'b1;
    step();
    chk("restart_addr0", {30'd0, out_addr}, 32'd0);
    out_ready = 1'b0;
    step();
    do_reset();
    in_valid = 1'b0;

    // err_cnt saturation.
    pulse_start();
    in_valid = 1'b1;
    set_fields(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int k = 0; k < 260; k++) step();
    chk("err_sat", {24'd0, err_cnt}, 32'd255);
    in_valid = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      f_op  = op_pool[$urandom_range(0, 9)];
      f_rd  = 5'($urandom); f_rs1 = 5'($urandom); f_rs2 = 5'($urandom);
      f_f3  = 3'($urandom); f_f7  = 7'($urandom);
      case ($urandom_range(0, 3))
        0: f_imm = int'($urandom_range(0, 8191)) - 4096;
        1: f_imm = $urandom;
        2: f_imm = $urandom & 32'hFFFFF000;
        default: f_imm = int'($urandom_range(0, 2097151)) - 1048576;
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 15) == 0);
      step();
    end
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
